write_back: RTL

- Final pipeline stage and the consumer side of the execute-to-write interface.
- Takes one executed result per transaction and commits it: register-file write, optional upper-half write, flags update, or a memory store through a wait-request bus.
- Single register write port, so multi-write transactions take several cycles and hold the execute stage.

---
 rtl/write_back_if.sv | 73 +++++++
 rtl/write_back.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/write_back_if.sv
`default_nettype none
// ============================================================================
//  Module      : write_back_if
//  Description : Execute-to-write-back interface. The slave modport is the
//                write-back stage; the master modport is the environment
//                (execute stage, register file and memory bus).
//                The optional retire_count signal exists only when
//                WRITE_BACK_RETIRE_COUNT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface write_back_if #(
    parameter int REG_COUNT = 32
) ();
    localparam int IDX_W = $clog2(REG_COUNT);

    // execute side
    logic              in_valid;
    logic              in_hold;
    logic [31:0]       in_pc;
    logic [IDX_W-1:0]  in_target_register;
    logic              in_is_writing_memory;
    logic [3:0]        in_flags;
    logic [31:0]       in_target_value;
    logic              in_has_upper_value;
    logic [31:0]       in_upper_value;
    logic [31:0]       in_adjustment_value;
    logic              in_has_flushed;
    // register file side
    logic [IDX_W-1:0]  reg_read_index;
    logic [31:0]       reg_read_value;
    logic              reg_write_enable;
    logic [IDX_W-1:0]  reg_write_index;
    logic [31:0]       reg_write_value;
    logic              flags_write_enable;
    logic [3:0]        flags_value;
    // memory side
    logic              mem_write;
    logic [31:0]       mem_address;
    logic [31:0]       mem_writedata;
    logic              mem_waitrequest;
    // status
    logic [31:0]       retired_pc;
`ifdef WRITE_BACK_RETIRE_COUNT_EN
    logic [31:0]       retire_count;
`endif

    modport slave (
        input  in_valid, in_pc, in_target_register, in_is_writing_memory,
               in_flags, in_target_value, in_has_upper_value, in_upper_value,
               in_adjustment_value, in_has_flushed, reg_read_value,
               mem_waitrequest,
        output in_hold, reg_read_index, reg_write_enable, reg_write_index,
               reg_write_value, flags_write_enable, flags_value, mem_write,
               mem_address, mem_writedata, retired_pc
`ifdef WRITE_BACK_RETIRE_COUNT_EN
        , output retire_count
`endif
    );

    modport master (
        output in_valid, in_pc, in_target_register, in_is_writing_memory,
               in_flags, in_target_value, in_has_upper_value, in_upper_value,
               in_adjustment_value, in_has_flushed, reg_read_value,
               mem_waitrequest,
        input  in_hold, reg_read_index, reg_write_enable, reg_write_index,
               reg_write_value, flags_write_enable, flags_value, mem_write,
               mem_address, mem_writedata, retired_pc
`ifdef WRITE_BACK_RETIRE_COUNT_EN
        , input retire_count
`endif
    );
endinterface
`default_nettype wire

// File: rtl/write_back.sv
`default_nettype none
// ============================================================================
//  Module      : write_back
//  Description : Final pipeline stage. Commits one executed result per
//                transaction: register write, optional upper-half write,
//                flags update, or a store over a wait-request bus.
//                Optional feature macro: WRITE_BACK_RETIRE_COUNT_EN adds a
//                32-bit count of non-flushed retired transactions.
//  Revision    : 1.0  initial release
// ============================================================================
module write_back #(
    parameter int REG_COUNT   = 32,
    parameter int FLAGS_INDEX = 31
) (
    input  wire logic    clock,
    input  wire logic    reset_n,
    write_back_if.slave  bus
);
    localparam int IDX_W = $clog2(REG_COUNT);
    localparam logic [IDX_W-1:0] c_FLAGS_IDX = IDX_W'(FLAGS_INDEX);
    localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(REG_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRIMARY = 2'd1,
        ST_UPPER   = 2'd2,
        ST_STORE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    // captured transaction
    logic [31:0]      pc_q, pc_d;
    logic [IDX_W-1:0] target_q, target_d;
    logic             flushed_q, flushed_d;
    logic             has_upper_q, has_upper_d;
    logic [31:0]      upper_q, upper_d;
    logic [31:0]      adj_q, adj_d;
    // registered outputs
    logic             reg_we_q, reg_we_d;
    logic [IDX_W-1:0] reg_idx_q, reg_idx_d;
    logic [31:0]      reg_val_q, reg_val_d;
    logic             flags_we_q, flags_we_d;
    logic [3:0]       flags_val_q, flags_val_d;
    logic             mem_write_q, mem_write_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [31:0]      retired_pc_q, retired_pc_d;
`ifdef WRITE_BACK_RETIRE_COUNT_EN
    logic [31:0]      retire_count_q, retire_count_d;
`endif

    logic             w_goes_upper;
    logic             w_done;
    logic             w_accept;
    logic [IDX_W-1:0] w_upper_idx;

    // Completion of the current transaction and acceptance of the next one
    always_comb begin
        w_goes_upper = has_upper_q && !flushed_q;
        w_upper_idx  = (target_q == c_LAST_IDX) ? '0 : target_q + IDX_W'(1);
        w_done       = ((state_q == ST_PRIMARY) && !w_goes_upper) ||
                       (state_q == ST_UPPER) ||
                       ((state_q == ST_STORE) && !bus.mem_waitrequest);
        w_accept     = bus.in_valid && ((state_q == ST_IDLE) || w_done);
    end

    // Next-state, capture and output strobe computation
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        flushed_d    = flushed_q;
        has_upper_d  = has_upper_q;
        upper_d      = upper_q;
        adj_d        = adj_q;
        reg_we_d     = 1'b0;
        reg_idx_d    = '0;
        reg_val_d    = '0;
        flags_we_d   = 1'b0;
        flags_val_d  = '0;
        mem_write_d  = 1'b0;
        mem_wdata_d  = '0;
        retired_pc_d = retired_pc_q;
`ifdef WRITE_BACK_RETIRE_COUNT_EN
        retire_count_d = retire_count_q;
`endif

        if (w_done && !flushed_q) begin
            retired_pc_d = pc_q;
`ifdef WRITE_BACK_RETIRE_COUNT_EN
            retire_count_d = retire_count_q + 32'd1;
`endif
        end

        if ((state_q == ST_PRIMARY) && w_goes_upper) begin
            // Second register write; wrapping onto r0 is dropped.
            state_d   = ST_UPPER;
            reg_we_d  = (w_upper_idx != '0);
            reg_idx_d = w_upper_idx;
            reg_val_d = upper_q;
        end else if ((state_q == ST_STORE) && !w_done) begin
            // Request and data held while the bus stalls.
            mem_write_d = 1'b1;
            mem_wdata_d = mem_wdata_q;
        end else if (w_done) begin
            state_d = ST_IDLE;
        end

        if (w_accept) begin
            pc_d        = bus.in_pc;
            target_d    = bus.in_target_register;
            flushed_d   = bus.in_has_flushed;
            has_upper_d = bus.in_has_upper_value;
            upper_d     = bus.in_upper_value;
            adj_d       = bus.in_adjustment_value;
            if (bus.in_has_flushed) begin
                // Squashed: occupies one PRIMARY cycle with no effect.
                state_d = ST_PRIMARY;
            end else if (bus.in_is_writing_memory) begin
                state_d     = ST_STORE;
                mem_write_d = 1'b1;
                mem_wdata_d = bus.in_target_value;
                flags_we_d  = 1'b1;
                flags_val_d = bus.in_flags;
            end else begin
                state_d    = ST_PRIMARY;
                reg_we_d   = (bus.in_target_register != '0);
                reg_idx_d  = bus.in_target_register;
                reg_val_d  = bus.in_target_value;
                // A direct write to the flags register overrides the update.
                if (bus.in_target_register != c_FLAGS_IDX) begin
                    flags_we_d  = 1'b1;
                    flags_val_d = bus.in_flags;
                end
            end
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            target_q     <= '0;
            flushed_q    <= 1'b0;
            has_upper_q  <= 1'b0;
            upper_q      <= '0;
            adj_q        <= '0;
            reg_we_q     <= 1'b0;
            reg_idx_q    <= '0;
            reg_val_q    <= '0;
            flags_we_q   <= 1'b0;
            flags_val_q  <= '0;
            mem_write_q  <= 1'b0;
            mem_wdata_q  <= '0;
            retired_pc_q <= '0;
`ifdef WRITE_BACK_RETIRE_COUNT_EN
            retire_count_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            flushed_q    <= flushed_d;
            has_upper_q  <= has_upper_d;
            upper_q      <= upper_d;
            adj_q        <= adj_d;
            reg_we_q     <= reg_we_d;
            reg_idx_q    <= reg_idx_d;
            reg_val_q    <= reg_val_d;
            flags_we_q   <= flags_we_d;
            flags_val_q  <= flags_val_d;
            mem_write_q  <= mem_write_d;
            mem_wdata_q  <= mem_wdata_d;
            retired_pc_q <= retired_pc_d;
`ifdef WRITE_BACK_RETIRE_COUNT_EN
            retire_count_q <= retire_count_d;
`endif
        end
    end

    // The address register is read during STORE; the stage issues no
    // register writes there, so the computed address stays stable.
    assign bus.reg_read_index     = target_q;
    assign bus.mem_address        = mem_write_q ? (bus.reg_read_value + adj_q) : 32'd0;
    assign bus.mem_write          = mem_write_q;
    assign bus.mem_writedata      = mem_wdata_q;
    assign bus.reg_write_enable   = reg_we_q;
    assign bus.reg_write_index    = reg_idx_q;
    assign bus.reg_write_value    = reg_val_q;
    assign bus.flags_write_enable = flags_we_q;
    assign bus.flags_value        = flags_val_q;
    assign bus.retired_pc         = retired_pc_q;
    assign bus.in_hold            = bus.in_valid && !((state_q == ST_IDLE) || w_done);
`ifdef WRITE_BACK_RETIRE_COUNT_EN
    assign bus.retire_count       = retire_count_q;
`endif

endmodule
`default_nettype wire
